// File: rtl/key_event_queue_pkg.sv
// Shared definitions for the key event queue: repeat FSM encodings,
// default typematic timing and the repeat-counter width helper.
package key_event_queue_pkg;

    typedef enum logic [1:0] {
        KQ_IDLE   = 2'd0,
        KQ_DELAY  = 2'd1,
        KQ_REPEAT = 2'd2
    } kq_state_t;

    // 500 ms initial delay and 10 Hz repeat rate at 50 MHz
    localparam int unsigned KQ_DELAY_CYC_DFLT  = 25_000_000;
    localparam int unsigned KQ_PERIOD_CYC_DFLT = 5_000_000;

    function automatic int unsigned kq_cnt_w(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an occupancy counter.
// A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_en;
    logic              wr_en;

    assign rd_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_en   = pop && rd_valid;
    assign wr_en    = push && (!full || pop_en);
    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Key event buffer with typematic auto-repeat, delivering ASCII codes to the
// editor over valid/ready; holds the repeat FSM, push mux and overflow flag.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int          DATA_W     = 8,
    parameter int          DEPTH      = 16,
    parameter int unsigned DELAY_CYC  = KQ_DELAY_CYC_DFLT,
    parameter int unsigned PERIOD_CYC = KQ_PERIOD_CYC_DFLT
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     key_valid,
    input  logic [DATA_W-1:0]        key_data,
    input  logic                     key_held,
    input  logic                     repeat_en,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int unsigned           CNT_W       = kq_cnt_w(DELAY_CYC, PERIOD_CYC);
    localparam logic [CNT_W-1:0]      DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0]      PERIOD_LAST = CNT_W'(PERIOD_CYC - 1);

    kq_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] last_key, last_key_n;
    logic              tick;
    logic              push_req;
    logic [DATA_W-1:0] push_data;
    logic              full;
    logic              drop;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= KQ_IDLE;
            cnt      <= '0;
            last_key <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_key <= last_key_n;
        end
    end

    // A fresh key restarts the delay and pre-empts any repeat tick this cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_key_n = last_key;
        tick       = 1'b0;
        if (key_valid) begin
            last_key_n = key_data;
            cnt_n      = '0;
            state_n    = KQ_DELAY;
        end else begin
            case (state)
                KQ_DELAY, KQ_REPEAT: begin
                    if (!key_held || !repeat_en) begin
                        state_n = KQ_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == ((state == KQ_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
                        tick    = 1'b1;
                        cnt_n   = '0;
                        state_n = KQ_REPEAT;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = KQ_IDLE;
                end
            endcase
        end
    end

    assign push_req  = key_valid || tick;
    assign push_data = key_valid ? key_data : last_key;
    // Only a lost keystroke is reported; a lost repeat is harmless.
    assign drop      = key_valid && full && !(out_valid && out_ready);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_data),
        .pop       (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (out_data),
        .full      (full),
        .count     (count)
    );

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with short typematic timing and a 4-entry FIFO.
module tb_key_event_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic              sys_clk;
    logic              rst_n;
    logic              key_valid;
    logic [DATA_W-1:0] key_data;
    logic              key_held;
    logic              repeat_en;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [2:0]        count;
    logic              overflow;
    logic              clr_overflow;

    int checks = 0;
    int errors = 0;

    key_event_queue #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .DELAY_CYC  (20),
        .PERIOD_CYC (5)
    ) dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .key_valid    (key_valid),
        .key_data     (key_data),
        .key_held     (key_held),
        .repeat_en    (repeat_en),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [DATA_W-1:0] code);
        key_valid = 1'b1;
        key_data  = code;
        step();
        key_valid = 1'b0;
    endtask

    initial begin
        logic [40:0] seen;
        logic [40:0] seen_exp;
        int          n_seen;
        int          first_j;
        logic [7:0]  drain_exp [4];

        rst_n        = 1'b0;
        key_valid    = 1'b0;
        key_data     = '0;
        key_held     = 1'b0;
        repeat_en    = 1'b1;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;

        // 1: reset behaviour
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        pulse(8'h55);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_data", out_data, 8'h55);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
        chk("async_count", count, 0);
        chk("async_data", out_data, 0);
        chk("async_ovf", overflow, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_count", count, 0);

        // 2: buffering and in-order delivery
        pulse(8'h41);
        pulse(8'h42);
        pulse(8'h43);
        chk("three_count", count, 3);
        chk("three_head", out_data, 8'h41);
        out_ready = 1'b1;
        step();
        chk("drain1_data", out_data, 8'h42);
        chk("drain1_count", count, 2);
        step();
        chk("drain2_data", out_data, 8'h43);
        step();
        chk("drain3_valid", out_valid, 0);
        chk("drain3_count", count, 0);

        // 3: typematic repeat
        key_held = 1'b1;
        pulse(8'h61);
        chk("rep_orig", out_data, 8'h61);
        n_seen = out_valid ? 1 : 0;
        seen   = '0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (out_valid) begin
                seen[i] = 1'b1;
                n_seen++;
                chk("rep_code", out_data, 8'h61);
            end
        end
        key_held = 1'b0;
        seen_exp = '0;
        seen_exp[20] = 1'b1;
        seen_exp[25] = 1'b1;
        seen_exp[30] = 1'b1;
        seen_exp[35] = 1'b1;
        seen_exp[40] = 1'b1;
        chk("rep_times", seen, seen_exp);
        chk("rep_total", n_seen, 6);
        n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) n_seen++;
        end
        chk("rep_stop", n_seen, 0);

        // 4: overflow on a full FIFO
        out_ready = 1'b0;
        pulse(8'h71);
        pulse(8'h72);
        pulse(8'h73);
        pulse(8'h74);
        chk("fill_ovf_clear", overflow, 0);
        pulse(8'h75);
        chk("full_count", count, 4);
        chk("full_ovf", overflow, 1);
        chk("full_head", out_data, 8'h71);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // 5: push and pop together while full
        key_valid = 1'b1;
        key_data  = 8'h76;
        out_ready = 1'b1;
        step();
        key_valid = 1'b0;
        out_ready = 1'b0;
        chk("pp_count", count, 4);
        chk("pp_ovf", overflow, 0);
        drain_exp[0] = 8'h72;
        drain_exp[1] = 8'h73;
        drain_exp[2] = 8'h74;
        drain_exp[3] = 8'h76;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain%0d", i), out_data, drain_exp[i]);
            step();
        end
        chk("pp_empty", out_valid, 0);

        // 6: new key coincident with a repeat tick
        key_held = 1'b1;
        pulse(8'h61);
        n_seen = 0;
        for (int i = 1; i <= 29; i++) begin
            step();
            if (out_valid) n_seen++;
        end
        chk("co_pre_repeats", n_seen, 2);
        key_valid = 1'b1;
        key_data  = 8'h62;
        step();
        key_valid = 1'b0;
        chk("co_valid", out_valid, 1);
        chk("co_data", out_data, 8'h62);
        chk("co_count", count, 1);
        step();
        chk("co_single", count, 0);
        n_seen  = 0;
        first_j = 0;
        for (int j = 2; j <= 20; j++) begin
            step();
            if (out_valid) begin
                n_seen++;
                if (first_j == 0) first_j = j;
                chk("co_rep_code", out_data, 8'h62);
            end
        end
        key_held = 1'b0;
        chk("co_rep_when", first_j, 20);
        chk("co_rep_count", n_seen, 1);
        n_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) n_seen++;
        end
        chk("co_stop", n_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
